// File: rtl/networkadapter_conf_reader.sv
// rtl/networkadapter_conf_reader.sv - boot-time reader that caches NA configuration values
//
// Walks the NA configuration register space after a start pulse. It reads tile ID,
// tile count, feature bits and compute-tile count, then reads the compute-tile list
// into a local cache.
//   clk, rst              clock, asynchronous active-high reset
//   start                 one-cycle scan request (ignored while busy)
//   bus_*                 initiator side of the configuration bus (reads only)
//   busy, done, error     scan status; done/error stay set until the next start
//   truncated             compute-tile count exceeded the cache capacity
//   tile_id .. num_cts    cached header values
//   ct_idx, ct_id         combinational lookup into the compute-tile list cache
module networkadapter_conf_reader #(
    parameter int MAX_CTS   = 16,
    parameter int TIMEOUT   = 15,
    parameter int MAX_RETRY = 3,
    localparam int IW = (MAX_CTS > 1) ? $clog2(MAX_CTS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          bus_stb_o,
    output logic [15:0]   bus_adr_o,
    output logic          bus_we_o,
    output logic [31:0]   bus_dat_o,
    input  logic [31:0]   bus_dat_i,
    input  logic          bus_ack_i,
    input  logic          bus_err_i,
    input  logic          bus_rty_i,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          truncated,
    output logic [15:0]   tile_id,
    output logic [15:0]   num_tiles,
    output logic          conf_mpsimple,
    output logic          conf_dma,
    output logic [15:0]   num_cts,
    input  logic [IW-1:0] ct_idx,
    output logic [15:0]   ct_id
);

    localparam int CW = $clog2(MAX_CTS + 1);                 // holds 0..MAX_CTS
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1; // holds 0..TIMEOUT-1
    localparam int RW = $clog2(MAX_RETRY + 2);               // holds 0..MAX_RETRY

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_GAP, S_DONE, S_ERR} state_t;

    state_t          state, state_next;
    logic [1:0]      hdr_sel;    // which header word is being read
    logic            in_list;    // header done, reading list words
    logic [CW-1:0]   list_idx;
    logic [CW-1:0]   list_len;   // min(num_cts, MAX_CTS)
    logic            last;       // the access just completed was the final one
    logic [WW-1:0]   wait_cnt;
    logic [RW-1:0]   retry_cnt;
    logic [15:0]     cache [MAX_CTS];

    // Response decode with priority err > ack > rty.
    logic resp_err, resp_ack, resp_rty;
    logic retry_exhausted, wait_expired;
    assign resp_err        = bus_err_i;
    assign resp_ack        = bus_ack_i & ~bus_err_i;
    assign resp_rty        = bus_rty_i & ~bus_ack_i & ~bus_err_i;
    assign retry_exhausted = (retry_cnt == RW'(MAX_RETRY));
    assign wait_expired    = (wait_cnt == WW'(TIMEOUT - 1));

    logic          cts_over;
    logic [CW-1:0] n_new;
    logic [CW-1:0] list_next;
    logic [15:0]   list_next_w;
    logic [15:0]   list_adr_next;
    logic [15:0]   hdr_adr_next;
    logic [15:0]   entry;

    assign cts_over      = (bus_dat_i[15:0] > 16'(MAX_CTS));
    assign n_new         = cts_over ? CW'(MAX_CTS) : bus_dat_i[CW-1:0];
    assign list_next     = list_idx + CW'(1);
    assign list_next_w   = 16'(list_next);
    assign list_adr_next = 16'h0200 + (list_next_w << 1);
    // Two list entries share each 32-bit word; even entries sit in the upper half.
    assign entry         = list_idx[0] ? bus_dat_i[15:0] : bus_dat_i[31:16];

    always_comb begin
        hdr_adr_next = 16'h0000;
        case (hdr_sel)
            2'd0:    hdr_adr_next = 16'h0004;
            2'd1:    hdr_adr_next = 16'h000c;
            2'd2:    hdr_adr_next = 16'h0028;
            default: hdr_adr_next = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_next = S_REQ;
            end
            S_REQ: begin
                if (resp_err)      state_next = S_ERR;
                else if (resp_ack) state_next = S_GAP;
                else if (resp_rty) state_next = retry_exhausted ? S_ERR : S_GAP;
                else if (wait_expired) state_next = S_ERR;
            end
            S_GAP: state_next = last ? S_DONE : S_REQ;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_adr_o     <= 16'h0000;
            truncated     <= 1'b0;
            tile_id       <= 16'h0000;
            num_tiles     <= 16'h0000;
            conf_mpsimple <= 1'b0;
            conf_dma      <= 1'b0;
            num_cts       <= 16'h0000;
            hdr_sel       <= 2'd0;
            in_list       <= 1'b0;
            list_idx      <= '0;
            list_len      <= '0;
            last          <= 1'b0;
            wait_cnt      <= '0;
            retry_cnt     <= '0;
            for (int i = 0; i < MAX_CTS; i++) cache[i] <= 16'h0000;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        bus_adr_o <= 16'h0000;
                        truncated <= 1'b0;
                        hdr_sel   <= 2'd0;
                        in_list   <= 1'b0;
                        list_idx  <= '0;
                        list_len  <= '0;
                        last      <= 1'b0;
                        wait_cnt  <= '0;
                        retry_cnt <= '0;
                        for (int i = 0; i < MAX_CTS; i++) cache[i] <= 16'h0000;
                    end
                end
                S_REQ: begin
                    if (resp_err) begin
                        wait_cnt <= '0;
                    end else if (resp_ack) begin
                        wait_cnt  <= '0;
                        retry_cnt <= '0;
                        if (!in_list) begin
                            case (hdr_sel)
                                2'd0: tile_id   <= bus_dat_i[15:0];
                                2'd1: num_tiles <= bus_dat_i[15:0];
                                2'd2: begin
                                    conf_mpsimple <= bus_dat_i[0];
                                    conf_dma      <= bus_dat_i[1];
                                end
                                default: begin
                                    num_cts   <= bus_dat_i[15:0];
                                    truncated <= cts_over;
                                    list_len  <= n_new;
                                end
                            endcase
                            if (hdr_sel == 2'd3) begin
                                in_list   <= 1'b1;
                                list_idx  <= '0;
                                bus_adr_o <= 16'h0200;
                                last      <= (n_new == '0);
                            end else begin
                                hdr_sel   <= hdr_sel + 2'd1;
                                bus_adr_o <= hdr_adr_next;
                            end
                        end else begin
                            cache[list_idx[IW-1:0]] <= entry;
                            list_idx  <= list_next;
                            bus_adr_o <= list_adr_next;
                            last      <= (list_next == list_len);
                        end
                    end else if (resp_rty) begin
                        // Address is unchanged, so the access is reissued after the gap.
                        wait_cnt  <= '0;
                        retry_cnt <= retry_cnt + RW'(1);
                    end else if (!wait_expired) begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    logic [CW-1:0] ct_idx_w;
    assign ct_idx_w = CW'(ct_idx);
    assign ct_id    = (ct_idx_w < list_len) ? cache[ct_idx] : 16'h0000;

    assign bus_stb_o = (state == S_REQ);
    assign busy      = (state == S_REQ) || (state == S_GAP);
    assign done      = (state == S_DONE);
    assign error     = (state == S_ERR);
    assign bus_we_o  = 1'b0;
    assign bus_dat_o = 32'h0000_0000;

endmodule

// File: tb/tb_networkadapter_conf_reader.sv
// tb/tb_networkadapter_conf_reader.sv - directed self-checking bench for networkadapter_conf_reader
module tb_networkadapter_conf_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        bus_stb_o;
    logic [15:0] bus_adr_o;
    logic        bus_we_o;
    logic [31:0] bus_dat_o;
    logic [31:0] bus_dat_i;
    logic        bus_ack_i;
    logic        bus_err_i;
    logic        bus_rty_i;
    logic        busy, done, error, truncated;
    logic [15:0] tile_id, num_tiles, num_cts, ct_id;
    logic        conf_mpsimple, conf_dma;
    logic [3:0]  ct_idx;

    int checks = 0;
    int errors = 0;

    networkadapter_conf_reader #(.MAX_CTS(16), .TIMEOUT(15), .MAX_RETRY(3)) dut (
        .clk(clk), .rst(rst), .start(start),
        .bus_stb_o(bus_stb_o), .bus_adr_o(bus_adr_o), .bus_we_o(bus_we_o),
        .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i),
        .bus_err_i(bus_err_i), .bus_rty_i(bus_rty_i),
        .busy(busy), .done(done), .error(error), .truncated(truncated),
        .tile_id(tile_id), .num_tiles(num_tiles), .conf_mpsimple(conf_mpsimple),
        .conf_dma(conf_dma), .num_cts(num_cts), .ct_idx(ct_idx), .ct_id(ct_id)
    );

    always #5 clk = ~clk;

    // Slave model configuration
    logic [15:0] s_tile, s_ntiles, s_ncts;
    logic [31:0] s_conf;
    logic [15:0] s_list [64];
    logic [15:0] err_adr, nores_adr, rty_adr;
    int          rty_limit, rty_base;

    // Bus observers
    int          rty_seen = 0;
    int          log_n = 0;
    int          stb_cnt = 0;
    logic        stb_d = 1'b0;
    logic [15:0] log_adr [256];

    always_comb begin
        bus_ack_i = 1'b0;
        bus_err_i = 1'b0;
        bus_rty_i = 1'b0;
        bus_dat_i = 32'h0;
        if (bus_stb_o) begin
            if (bus_adr_o == err_adr) bus_err_i = 1'b1;
            else if (bus_adr_o == nores_adr) bus_ack_i = 1'b0;
            else if (bus_adr_o == rty_adr && (rty_seen - rty_base) < rty_limit) bus_rty_i = 1'b1;
            else begin
                bus_ack_i = 1'b1;
                if (bus_adr_o == 16'h0000) bus_dat_i = {16'h0, s_tile};
                else if (bus_adr_o == 16'h0004) bus_dat_i = {16'h0, s_ntiles};
                else if (bus_adr_o == 16'h000c) bus_dat_i = s_conf;
                else if (bus_adr_o == 16'h0028) bus_dat_i = {16'hdead, s_ncts};
                else if (bus_adr_o >= 16'h0200 && bus_adr_o < 16'h0280)
                    bus_dat_i = {s_list[((bus_adr_o - 16'h0200) >> 2) * 2],
                                 s_list[((bus_adr_o - 16'h0200) >> 2) * 2 + 1]};
            end
        end
    end

    always @(posedge clk) begin
        stb_d <= bus_stb_o;
        if (bus_stb_o) stb_cnt <= stb_cnt + 1;
        if (bus_stb_o && bus_rty_i) rty_seen <= rty_seen + 1;
        if (bus_stb_o && !stb_d) begin
            log_adr[log_n & 255] <= bus_adr_o;
            log_n <= log_n + 1;
        end
    end

    int cycles;
    int base;

    task automatic slave_default();
        s_tile = 16'd5; s_ntiles = 16'd16; s_conf = 32'h3; s_ncts = 16'd3;
        for (int i = 0; i < 64; i++) s_list[i] = 16'h0;
        s_list[0] = 16'd2; s_list[1] = 16'd7; s_list[2] = 16'd9;
        err_adr = 16'hffff; nores_adr = 16'hffff; rty_adr = 16'hffff;
        rty_limit = 0; rty_base = rty_seen;
    endtask

    task automatic run_scan();
        base = log_n;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cycles = 0;
        while (!(done || error) && cycles < 300) begin
            @(negedge clk);
            cycles++;
        end
        if (cycles >= 300) begin
            errors++;
            $display("FAIL scan_timeout: no done/error within %0d cycles", cycles);
        end
        checks++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ct_idx = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({busy, done, error, truncated, bus_stb_o} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b exp 00000", {busy, done, error, truncated, bus_stb_o}); end
        checks++; if (bus_adr_o !== 16'h0) begin
            errors++; $display("FAIL reset_adr: got %h exp 0000", bus_adr_o); end
        checks++; if ({tile_id, num_tiles, num_cts, ct_id} !== 64'h0) begin
            errors++; $display("FAIL reset_values: got %h exp 0", {tile_id, num_tiles, num_cts, ct_id}); end
        checks++; if ({bus_we_o, bus_dat_o} !== 33'h0) begin
            errors++; $display("FAIL reset_we_dat: got %h exp 0", {bus_we_o, bus_dat_o}); end
    endtask

    task automatic test_basic();
        logic [15:0] exp_adr [7];
        logic [15:0] exp_ct [4];
        exp_adr = '{16'h0, 16'h4, 16'hc, 16'h28, 16'h200, 16'h202, 16'h204};
        exp_ct = '{16'd2, 16'd7, 16'd9, 16'd0};
        slave_default();
        run_scan();
        checks++; if (cycles !== 14) begin
            errors++; $display("FAIL basic_latency: got %0d exp 14", cycles); end
        checks++; if (log_n - base !== 7) begin
            errors++; $display("FAIL basic_accesses: got %0d exp 7", log_n - base); end
        for (int i = 0; i < 7; i++) begin
            checks++; if (log_adr[(base + i) & 255] !== exp_adr[i]) begin
                errors++; $display("FAIL basic_adr%0d: got %h exp %h", i, log_adr[(base + i) & 255], exp_adr[i]); end
        end
        checks++; if ({done, error, busy, truncated} !== 4'b1000) begin
            errors++; $display("FAIL basic_flags: got %b exp 1000", {done, error, busy, truncated}); end
        checks++; if ({tile_id, num_tiles, num_cts, conf_mpsimple, conf_dma} !== {16'd5, 16'd16, 16'd3, 2'b11}) begin
            errors++; $display("FAIL basic_header: got %h/%h/%h/%b%b exp 5/16/3/11",
                                tile_id, num_tiles, num_cts, conf_mpsimple, conf_dma); end
        for (int i = 0; i < 4; i++) begin
            ct_idx = 4'(i); #1;
            checks++; if (ct_id !== exp_ct[i]) begin
                errors++; $display("FAIL basic_ct%0d: got %0d exp %0d", i, ct_id, exp_ct[i]); end
        end
    endtask

    task automatic test_zero();
        slave_default();
        s_ncts = 16'd0;
        run_scan();
        checks++; if (log_n - base !== 4) begin
            errors++; $display("FAIL zero_accesses: got %0d exp 4", log_n - base); end
        checks++; if ({done, truncated, cycles} !== {2'b10, 32'd8}) begin
            errors++; $display("FAIL zero_status: got done=%b trunc=%b cyc=%0d exp 1 0 8", done, truncated, cycles); end
        for (int i = 0; i < 3; i++) begin
            ct_idx = 4'(i); #1;
            checks++; if (ct_id !== 16'd0) begin
                errors++; $display("FAIL zero_ct%0d: got %0d exp 0", i, ct_id); end
        end
    endtask

    task automatic test_truncate();
        slave_default();
        s_ncts = 16'd20;
        for (int i = 0; i < 20; i++) s_list[i] = 16'(100 + i);
        run_scan();
        checks++; if (log_n - base !== 20) begin
            errors++; $display("FAIL trunc_accesses: got %0d exp 20", log_n - base); end
        checks++; if (log_adr[(base + 19) & 255] !== 16'h021e) begin
            errors++; $display("FAIL trunc_last_adr: got %h exp 021e", log_adr[(base + 19) & 255]); end
        checks++; if ({done, truncated, num_cts} !== {2'b11, 16'd20}) begin
            errors++; $display("FAIL trunc_status: got done=%b trunc=%b num_cts=%0d exp 1 1 20", done, truncated, num_cts); end
        checks++; if (cycles !== 40) begin
            errors++; $display("FAIL trunc_latency: got %0d exp 40", cycles); end
        ct_idx = 4'd15; #1;
        checks++; if (ct_id !== 16'd115) begin
            errors++; $display("FAIL trunc_ct15: got %0d exp 115", ct_id); end
        ct_idx = 4'd6; #1;
        checks++; if (ct_id !== 16'd106) begin
            errors++; $display("FAIL trunc_ct6: got %0d exp 106", ct_id); end
    endtask

    task automatic test_err();
        int s;
        slave_default();
        s_tile = 16'h0033; s_ntiles = 16'h0044;
        err_adr = 16'h000c;
        run_scan();
        checks++; if ({error, done, busy, bus_stb_o} !== 4'b1000) begin
            errors++; $display("FAIL err_flags: got %b exp 1000", {error, done, busy, bus_stb_o}); end
        checks++; if ({tile_id, num_tiles} !== {16'h0033, 16'h0044}) begin
            errors++; $display("FAIL err_retained: got %h exp 00330044", {tile_id, num_tiles}); end
        checks++; if (cycles !== 5) begin
            errors++; $display("FAIL err_latency: got %0d exp 5", cycles); end
        s = stb_cnt;
        repeat (5) @(negedge clk);
        checks++; if (stb_cnt !== s) begin
            errors++; $display("FAIL err_no_stb: got %0d stb cycles exp 0", stb_cnt - s); end
    endtask

    task automatic test_timeout();
        int s;
        slave_default();
        nores_adr = 16'h0004;
        s = stb_cnt;
        run_scan();
        checks++; if ({error, done, bus_stb_o} !== 3'b100) begin
            errors++; $display("FAIL tmo_flags: got %b exp 100", {error, done, bus_stb_o}); end
        checks++; if (stb_cnt - s !== 16) begin
            errors++; $display("FAIL tmo_stb_cycles: got %0d exp 16", stb_cnt - s); end
        checks++; if (cycles !== 17) begin
            errors++; $display("FAIL tmo_latency: got %0d exp 17", cycles); end
    endtask

    task automatic test_retry();
        slave_default();
        rty_adr = 16'h0028; rty_limit = 2;
        run_scan();
        checks++; if (log_n - base !== 9) begin
            errors++; $display("FAIL rty_accesses: got %0d exp 9", log_n - base); end
        for (int i = 3; i < 6; i++) begin
            checks++; if (log_adr[(base + i) & 255] !== 16'h0028) begin
                errors++; $display("FAIL rty_adr%0d: got %h exp 0028", i, log_adr[(base + i) & 255]); end
        end
        checks++; if ({done, error, cycles} !== {2'b10, 32'd18}) begin
            errors++; $display("FAIL rty_done: got done=%b err=%b cyc=%0d exp 1 0 18", done, error, cycles); end
        ct_idx = 4'd2; #1;
        checks++; if (ct_id !== 16'd9) begin
            errors++; $display("FAIL rty_ct2: got %0d exp 9", ct_id); end
        slave_default();
        rty_adr = 16'h0028; rty_limit = 4;
        run_scan();
        checks++; if ({error, done, cycles} !== {2'b10, 32'd13}) begin
            errors++; $display("FAIL rty_exceed: got err=%b done=%b cyc=%0d exp 1 0 13", error, done, cycles); end
    endtask

    task automatic test_reset_mid();
        slave_default();
        s_ncts = 16'd16;
        for (int i = 0; i < 16; i++) s_list[i] = 16'(i + 1);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (12) @(negedge clk);
        ct_idx = 4'd1;
        #2 rst = 1'b1;
        #1;
        checks++; if ({busy, done, error, bus_stb_o, truncated} !== 5'b0) begin
            errors++; $display("FAIL mid_rst_flags: got %b exp 00000", {busy, done, error, bus_stb_o, truncated}); end
        checks++; if ({bus_adr_o, tile_id, num_tiles, num_cts, ct_id, conf_mpsimple, conf_dma} !== 82'h0) begin
            errors++; $display("FAIL mid_rst_values: got %h exp 0",
                                {bus_adr_o, tile_id, num_tiles, num_cts, ct_id, conf_mpsimple, conf_dma}); end
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_truncate();
        test_err();
        test_timeout();
        test_retry();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/networkadapter_conf_reader.md
Name: networkadapter_conf_reader

Overview:
- Bus initiator that walks the network adapter configuration register space at boot and caches the values the tile needs in local registers.
- Sits between tile-local boot and control logic and the slave port of the NA configuration block.
- Reads tile ID, tile count, feature bits, compute-tile count, and the compute-tile list.
- Exposes the cached values as static outputs plus an indexed lookup port for the compute-tile list.

Parameters:
MAX_CTS, 16, capacity of the local compute-tile list cache (1..128)
TIMEOUT, 15, cycles to wait for ack/err/rty on one access before flagging error
MAX_RETRY, 3, rty responses tolerated per access before flagging error

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins a scan (ignored while busy)
bus_stb_o  out  1  access request; held until response
bus_adr_o  out  16  byte address of current access
bus_we_o  out  1  always 0 (reads only)
bus_dat_o  out  32  always 0
bus_dat_i  in  32  read data, valid in the ack cycle
bus_ack_i  in  1  access complete
bus_err_i  in  1  access failed
bus_rty_i  in  1  retry requested
busy  out  1  scan in progress
done  out  1  scan completed successfully; sticky until next start
error  out  1  scan aborted; sticky until next start
truncated  out  1  num_cts exceeded MAX_CTS
tile_id  out  16  word 0x0 [15:0]
num_tiles  out  16  word 0x4 [15:0]
conf_mpsimple  out  1  word 0xc bit0
conf_dma  out  1  word 0xc bit1
num_cts  out  16  word 0x28 [15:0], unclipped
ct_idx  in  clog2(MAX_CTS)  lookup index
ct_id  out  16  cached list entry at ct_idx, combinational; 0 if ct_idx >= min(num_cts,MAX_CTS)

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE, bus_stb_o=0, bus_adr_o=0. All status flags, all captured outputs, and the list cache cleared to 0.
- FSM states: IDLE, REQ, GAP, DONE, ERR.
- IDLE/DONE/ERR + start: clear done, error, and truncated. Load header sequence 0x0, 0x4, 0xc, 0x28. Go to REQ.
- REQ:
  - bus_stb_o=1 with stable address.
  - A wait counter counts cycles with no response.
  - ack: capture data into the target register and go to GAP. Ack may be combinational with stb; capture in the same cycle.
  - err: go to ERR.
  - rty: increment retry count and go to GAP, reissuing the same address. If the count would exceed MAX_RETRY, go to ERR instead.
  - Wait counter reaching TIMEOUT with no response: go to ERR.
  - Priority when several responses arrive together: err > ack > rty.
- GAP:
  - bus_stb_o=0 for exactly one cycle.
  - Then issue the next access (or reissue), resetting the wait counter. The retry count resets only on address advance.
- List phase, after the 0x28 read: n = min(num_cts, MAX_CTS), truncated = (num_cts > MAX_CTS).
  - For i = 0..n-1, read address 0x200 + 2*i (16-bit arithmetic).
  - Entry = bus_dat_i[31:16] when i is even, bus_dat_i[15:0] when i is odd. Store at cache[i].
  - n=0: go directly to DONE after the 0x28 read.
- DONE: done=1, busy=0.
- ERR: error=1, busy=0, bus_stb_o=0. Values captured before the fault remain.
- busy=1 in REQ and GAP only.
- Minimum scan latency with zero-wait ack: 2*(4+n) cycles from start to done.
- A start that coincides with reset is ignored.
- Cache entries beyond n from a previous scan are cleared at start.

Test Plan:
1. Slave model with tile 5, 16 tiles, conf=0x3, num_cts=3, list {2,7,9}, zero-wait ack; start → 7 accesses at 0x0, 0x4, 0xc, 0x28, 0x200, 0x202, 0x204; done after 14 cycles; tile_id=5, num_tiles=16, conf_mpsimple=1, conf_dma=1, ct_id[0..2]=2,7,9, ct_id[3]=0.
2. num_cts=0 → exactly 4 accesses; done=1; truncated=0; all ct_id=0.
3. num_cts=20, MAX_CTS=16 → 16 list reads, last at 0x21e; truncated=1; num_cts=20; done=1.
4. err asserted on the 0xc read → error=1, done=0, busy=0; tile_id and num_tiles retain their captured values; no further stb.
5. Slave never responds on 0x4 → error asserted after 15 wait cycles; bus_stb_o low afterward.
6. rty twice then ack on 0x28 → same address reissued twice with a 1-cycle gap before each reissue; scan completes with done=1. A 4th rty in a row on one access (exceeding MAX_RETRY=3) → error=1. Assert rst mid-list → all outputs 0 immediately, with no clock edge required.
